at24_cmd_tx: RTL and testbench
==============================

# at24_cmd_tx

Controller-side transmitter for the switch-controller command bus (3-bit code `C` plus strobe `CLK`). It accepts one high-level request per handshake and expands it into one or more strobed code frames with fixed setup, high and gap times derived from the clock frequency. Multi-frame commands (start, discharge) are sequenced internally. Its outputs drive the `I_C0..2` / `I_CLK` inputs of the switch-controller top.

## Interface
Parameters:
- `FREQ`, 50000000, clock frequency in Hz
- `STROBE_US`, 1, strobe high time in µs; `STROBE_CYC = max(1, FREQ*STROBE_US/1000000)`
- `GAP_US`, 1, strobe low time after each high phase in µs; `GAP_CYC = max(1, FREQ*GAP_US/1000000)`
- `SETUP_CYC`, 2, cycles during which the code is stable with `CLK` low before the rising edge (≥1)

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-low reset (0 = reset)
- `req_valid`  in  1  request present
- `req_ready`  out  1  transmitter idle, request accepted when `req_valid & req_ready`
- `req_op`  in  3  0 pause, 1 plus, 2 minus, 3 ballast_p, 4 ballast_n, 5 start, 6 shutdown, 7 discharge
- `req_arg`  in  3  final code for discharge; legal values 1 and 3 only
- `O_C`  out  3  command code to controller
- `O_CLK`  out  1  command strobe; the controller latches `O_C` on its rising edge
- `busy`  out  1  sequence in progress
- `done`  out  1  one-cycle pulse after the last frame's gap
- `err`  out  1  one-cycle pulse: discharge request with illegal `req_arg`, rejected
- `abort`  in  1  only with `AT24_CMD_TX_ABORT_EN`

## Operation
- Frame list per op: 0–4 and 6 → single frame of code `req_op`; 5 → frames 5, 0; 7 → frames 7, 0, 7, 0, `req_arg`.
- On acceptance, op/arg are latched; the frame index starts at 0. Later changes to inputs have no effect.
- Discharge with `req_arg` ∉ {1,3}: handshake completes (accepted), no frame is sent, `err` pulses the next cycle, `done` does not pulse, and the block stays idle.
- FSM: IDLE → SETUP (`O_C` = frame code, `O_CLK`=0, `SETUP_CYC` cycles) → HIGH (`O_CLK`=1, `STROBE_CYC` cycles) → GAP (`O_CLK`=0, `GAP_CYC` cycles) → SETUP of the next frame, or DONE (1 cycle, `done`=1) → IDLE.
- `O_C` holds the last frame code through GAP and idle until the next frame's SETUP; it never changes while `O_CLK`=1.
- `req_ready` = 1 only in IDLE; `busy` = 1 in SETUP/HIGH/GAP/DONE.
- Single down-counter sized `$clog2(max(SETUP_CYC,STROBE_CYC,GAP_CYC)+1)`; no arithmetic overflow is possible.
- Reset values: `O_C`=0, `O_CLK`=0, `req_ready`=0 while reset is asserted and 1 from the first cycle after release, `busy`=0, `done`=0, `err`=0, FSM=IDLE.
- Reset mid-frame: `O_CLK` drops to 0 asynchronously, and the sequence is discarded with no `done`.

## Timing
- Accept at edge N → `O_C` valid and SETUP at N+1; `O_CLK` rises at N+1+SETUP_CYC.
- Frame length F = SETUP_CYC+STROBE_CYC+GAP_CYC cycles; single-frame op: `done` at N+1+F, `req_ready` at N+2+F.
- Start: `done` at N+1+2F; discharge: N+1+5F.
- Back-to-back requests: the next acceptance is at the earliest cycle that `req_ready` is 1.

## Configuration
- `AT24_CMD_TX_ABORT_EN` defined: `abort` port present. `abort`=1 in any busy state sets a sticky flag. The current frame completes through GAP, remaining frames are dropped, and one pause frame (code 0) is sent, then DONE. Abort during the final frame of pause, or during the inserted pause frame, adds nothing. Abort in IDLE is ignored.
- Undefined: no `abort` port, and sequences always run to completion.

## Test plan
- FREQ=50e6, SETUP_CYC=2: plus (op 1) → one `O_CLK` pulse exactly 50 cycles high with `O_C`=1; `done` at acceptance+103; `O_C` still 1 afterwards.
- Start (op 5) → two strobes with codes 5 then 0, rising edges 102 cycles apart; `busy` high for 205 cycles.
- Discharge op 7 with arg 3 → code sequence 7,0,7,0,3 across five strobes; `done` once at acceptance+511.
- Discharge with arg 2 → no strobe, `err` pulses once, `done` stays 0, `req_ready` returns to 1.
- Assert reset during the HIGH phase of minus → `O_CLK`=0 immediately, `O_C`=0, no `done`; a plus request after release transmits normally.
- With `AT24_CMD_TX_ABORT_EN`: discharge arg 1, `abort` pulsed during frame 2 → codes 7,0,0 observed, then `done`.

Source files
------------

// File: rtl/at24_cmd_tx.sv
// rtl/at24_cmd_tx.sv - command-bus transmitter: expands requests into strobed 3-bit code frames
// Optional abort input and pause-frame insertion enabled by AT24_CMD_TX_ABORT_EN.
module at24_cmd_tx #(
    parameter int FREQ      = 50000000,
    parameter int STROBE_US = 1,
    parameter int GAP_US    = 1,
    parameter int SETUP_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_op,
    input  logic [2:0] req_arg,
    output logic [2:0] O_C,
    output logic       O_CLK,
    output logic       busy,
    output logic       done,
    output logic       err
`ifdef AT24_CMD_TX_ABORT_EN
    ,
    input  logic       abort
`endif
);

    localparam longint STROBE_RAW = longint'(FREQ) * longint'(STROBE_US) / 64'd1000000;
    localparam longint GAP_RAW    = longint'(FREQ) * longint'(GAP_US) / 64'd1000000;
    localparam int STROBE_CYC = (STROBE_RAW < 1) ? 1 : int'(STROBE_RAW);
    localparam int GAP_CYC    = (GAP_RAW < 1) ? 1 : int'(GAP_RAW);
    localparam int MAX_SG     = (STROBE_CYC > GAP_CYC) ? STROBE_CYC : GAP_CYC;
    localparam int MAX_CYC    = (SETUP_CYC > MAX_SG) ? SETUP_CYC : MAX_SG;
    localparam int CW         = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYC - 1);
    localparam logic [CW-1:0] GAP_LD    = CW'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_HIGH  = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    op_q, op_d;
    logic [2:0]    arg_q, arg_d;
    logic [2:0]    idx_q, idx_d;
    logic          init_q, init_d;
    logic          ab_q, ab_d;
    logic          ins_q, ins_d;
    logic [2:0]    o_c_q, o_c_d;
    logic          o_clk_q, o_clk_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          abort_in;

`ifdef AT24_CMD_TX_ABORT_EN
    assign abort_in = abort;
`else
    assign abort_in = 1'b0;
`endif

    function automatic logic [2:0] frame_code(input logic [2:0] op, input logic [2:0] arg,
                                              input logic [2:0] idx);
        logic [2:0] code;
        code = op;
        if (op == 3'd5) begin
            code = (idx == 3'd0) ? 3'd5 : 3'd0;
        end else if (op == 3'd7) begin
            if (idx == 3'd4)      code = arg;
            else if (idx[0])      code = 3'd0;
            else                  code = 3'd7;
        end
        return code;
    endfunction

    function automatic logic [2:0] frame_last(input logic [2:0] op);
        logic [2:0] last;
        last = 3'd0;
        if (op == 3'd5)      last = 3'd1;
        else if (op == 3'd7) last = 3'd4;
        return last;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= 3'd0;
            arg_q   <= 3'd0;
            idx_q   <= 3'd0;
            init_q  <= 1'b0;
            ab_q    <= 1'b0;
            ins_q   <= 1'b0;
            o_c_q   <= 3'd0;
            o_clk_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            arg_q   <= arg_d;
            idx_q   <= idx_d;
            init_q  <= init_d;
            ab_q    <= ab_d;
            ins_q   <= ins_d;
            o_c_q   <= o_c_d;
            o_clk_q <= o_clk_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        arg_d   = arg_q;
        idx_d   = idx_q;
        init_d  = 1'b1;
        ins_d   = ins_q;
        err_d   = 1'b0;
        ab_d    = ab_q | (abort_in & (state_q != S_IDLE));
        case (state_q)
            S_IDLE: begin
                if (req_valid && init_q) begin
                    if (req_op == 3'd7 && req_arg != 3'd1 && req_arg != 3'd3) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_SETUP;
                        cnt_d   = SETUP_LD;
                        op_d    = req_op;
                        arg_d   = req_arg;
                        idx_d   = 3'd0;
                        ab_d    = 1'b0;
                        ins_d   = 1'b0;
                    end
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_HIGH;
                    cnt_d   = STROBE_LD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_HIGH: begin
                if (cnt_q == '0) begin
                    state_d = S_GAP;
                    cnt_d   = GAP_LD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (ins_q) begin
                    state_d = S_DONE;
                end else if (ab_d) begin
                    // A final frame that already carried a pause needs no extra pause frame.
                    if (idx_q == frame_last(op_q) && o_c_q == 3'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SETUP;
                        cnt_d   = SETUP_LD;
                        ins_d   = 1'b1;
                    end
                end else if (idx_q == frame_last(op_q)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_SETUP;
                    cnt_d   = SETUP_LD;
                    idx_d   = idx_q + 3'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        o_c_d = o_c_q;
        if (state_d == S_SETUP && state_q != S_SETUP) begin
            o_c_d = ins_d ? 3'd0 : frame_code(op_d, arg_d, idx_d);
        end
        o_clk_d = (state_d == S_HIGH);
        done_d  = (state_d == S_DONE);
    end

    assign req_ready = (state_q == S_IDLE) && init_q;
    assign busy      = (state_q != S_IDLE);
    assign O_C       = o_c_q;
    assign O_CLK     = o_clk_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_at24_cmd_tx.sv
// tb/tb_at24_cmd_tx.sv - directed self-checking bench for at24_cmd_tx
module tb_at24_cmd_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid = 1'b0;
    logic [2:0] req_op = 3'd0;
    logic [2:0] req_arg = 3'd0;
    logic       req_ready;
    logic [2:0] O_C;
    logic       O_CLK;
    logic       busy;
    logic       done;
    logic       err;
`ifdef AT24_CMD_TX_ABORT_EN
    logic       abort = 1'b0;
`endif

    at24_cmd_tx #(
        .FREQ(50000000), .STROBE_US(1), .GAP_US(1), .SETUP_CYC(2)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_arg(req_arg), .O_C(O_C), .O_CLK(O_CLK),
        .busy(busy), .done(done), .err(err)
`ifdef AT24_CMD_TX_ABORT_EN
        , .abort(abort)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   codes[$];
    int   rise_t[$];
    int   hi_len[$];
    int   done_n = 0, done_t = 0, err_n = 0, err_t = 0, busy_n = 0, hold_viol = 0, hi_cnt = 0;
    logic prev_clk = 1'b0;
    logic [2:0] cur_code = 3'd0;

    always @(negedge clk) begin
        if (O_CLK && !prev_clk) begin
            codes.push_back(int'(O_C));
            rise_t.push_back(cyc);
            cur_code = O_C;
            hi_cnt = 1;
        end else if (O_CLK) begin
            hi_cnt++;
            if (O_C !== cur_code) hold_viol++;
        end else if (prev_clk) begin
            hi_len.push_back(hi_cnt);
        end
        if (done) begin done_n++; done_t = cyc; end
        if (err)  begin err_n++;  err_t = cyc;  end
        if (busy) busy_n++;
        prev_clk = O_CLK;
    end

    int npass = 0;
    int ntotal = 0;

    task automatic chk(input string tag, input int got, input int exp);
        ntotal++;
        assert (got === exp) npass++;
        else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic clear_mon();
        codes.delete();
        rise_t.delete();
        hi_len.delete();
        done_n = 0; err_n = 0; busy_n = 0; hold_viol = 0;
    endtask

    task automatic send(input logic [2:0] op, input logic [2:0] arg, output int acc);
        int k;
        req_valid = 1'b1;
        req_op    = op;
        req_arg   = arg;
        k = 0;
        while (!req_ready && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("accept_ready", int'(req_ready), 1);
        @(negedge clk);
        acc       = cyc;
        req_valid = 1'b0;
        req_op    = 3'd6;
        req_arg   = 3'd2;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy || !req_ready) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("idle_reached", int'(req_ready && !busy), 1);
    endtask

    task automatic chk_codes(input string tag, input int exp[$]);
        chk({tag, "_n"}, codes.size(), exp.size());
        for (int i = 0; i < exp.size() && i < codes.size(); i++)
            chk(tag, codes[i], exp[i]);
    endtask

    int a, a2;

    initial begin
        @(negedge clk);
        chk("rst_o_c", int'(O_C), 0);
        chk("rst_o_clk", int'(O_CLK), 0);
        chk("rst_ready", int'(req_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", int'(req_ready), 1);

        // plus
        clear_mon();
        send(3'd1, 3'd0, a);
        wait_idle();
        chk_codes("plus_code", '{1});
        if (hi_len.size() > 0) chk("plus_hi_len", hi_len[0], 50);
        if (rise_t.size() > 0) chk("plus_rise_t", rise_t[0] - a, 2);
        chk("plus_done_n", done_n, 1);
        chk("plus_done_t", done_t - a, 102);
        chk("plus_o_c_hold", int'(O_C), 1);
        chk("plus_hold_viol", hold_viol, 0);

        // start
        clear_mon();
        send(3'd5, 3'd0, a);
        wait_idle();
        chk_codes("start_code", '{5, 0});
        if (rise_t.size() > 1) chk("start_rise_gap", rise_t[1] - rise_t[0], 102);
        chk("start_busy_n", busy_n, 205);
        chk("start_done_t", done_t - a, 204);

        // discharge arg 3
        clear_mon();
        send(3'd7, 3'd3, a);
        wait_idle();
        chk_codes("dis3_code", '{7, 0, 7, 0, 3});
        chk("dis3_done_n", done_n, 1);
        chk("dis3_done_t", done_t - a, 510);
        chk("dis3_hold_viol", hold_viol, 0);

        // discharge illegal arg
        clear_mon();
        send(3'd7, 3'd2, a);
        repeat (4) @(negedge clk);
        chk("dis2_n_codes", codes.size(), 0);
        chk("dis2_err_n", err_n, 1);
        chk("dis2_err_t", err_t - a, 0);
        chk("dis2_done_n", done_n, 0);
        chk("dis2_busy_n", busy_n, 0);
        chk("dis2_ready", int'(req_ready), 1);

        // back-to-back
        clear_mon();
        send(3'd3, 3'd0, a);
        send(3'd4, 3'd0, a2);
        wait_idle();
        chk("b2b_accept_gap", a2 - a, 104);
        chk_codes("b2b_code", '{3, 4});
        chk("b2b_done_n", done_n, 2);

        // reset during HIGH of minus
        clear_mon();
        send(3'd2, 3'd0, a);
        for (int k = 0; k < 200 && !O_CLK; k++) @(negedge clk);
        chk("minus_high_seen", int'(O_CLK), 1);
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_o_clk", int'(O_CLK), 0);
        chk("midrst_o_c", int'(O_C), 0);
        chk("midrst_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        chk("midrst_done_n", done_n, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        clear_mon();
        send(3'd1, 3'd0, a);
        wait_idle();
        chk_codes("post_rst_code", '{1});
        chk("post_rst_done_t", done_t - a, 102);

`ifdef AT24_CMD_TX_ABORT_EN
        clear_mon();
        send(3'd7, 3'd1, a);
        for (int k = 0; k < 400 && rise_t.size() < 2; k++) @(negedge clk);
        chk("abort_frame2_seen", rise_t.size(), 2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_idle();
        chk_codes("abort_code", '{7, 0, 0});
        chk("abort_done_n", done_n, 1);
`endif

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
